pipeline_stage_regs: RTL and testbench
======================================

Name: pipeline_stage_regs

Overview:
Holds the three forward pipeline register banks of the 5-stage MIPS-style core: IF/ID, ID/EX and EX/MEM. The fetch, decode and execute stages drive the `_d` inputs; the next stage reads the `_q` outputs. IF/ID supports a hold (enable) for load-use stalls. ID/EX inserts a bubble when the hazard unit asserts stall.

Parameters:
DATA_W, 32, width of PC, instruction, register data, immediate, ALU and branch-address fields
RADDR_W, 5, width of register-file address fields

Ports:
clk  in  1  rising-edge clock for all banks
reset  in  1  asynchronous, active-low; clears every register
ifid_en  in  1  IF/ID capture enable (driven by ~stall)
ifid_pc_d / ifid_pc_q  in / out  DATA_W  PC+1 of fetched instruction
ifid_instr_d / ifid_instr_q  in / out  32  fetched instruction word
idex_stall  in  1  load-use stall: bubble the ID/EX controls
idex_pc_d / idex_pc_q  in / out  DATA_W  PC+1 passed from IF/ID
idex_rs_data_d / idex_rs_data_q  in / out  DATA_W  register-file read port 1
idex_rt_data_d / idex_rt_data_q  in / out  DATA_W  register-file read port 2
idex_imm_d / idex_imm_q  in / out  DATA_W  sign-extended immediate
idex_rs_addr_d / idex_rs_addr_q  in / out  RADDR_W  instr[25:21]
idex_rt_addr_d / idex_rt_addr_q  in / out  RADDR_W  instr[20:16]
idex_rd_addr_d / idex_rd_addr_q  in / out  RADDR_W  instr[15:11]
idex_instr_d / idex_instr_q  in / out  32  instruction word (funct field for ALU)
idex_ctrl_d / idex_ctrl_q  in / out  10  {reg_dst[9], jump[8], branch[7], mem_read[6], mem_to_reg[5], mem_write[4], alu_src[3], alu_op[2:1], reg_write[0]}
exmem_branch_addr_d / exmem_branch_addr_q  in / out  DATA_W  computed branch target
exmem_alu_res_d / exmem_alu_res_q  in / out  DATA_W  ALU result / memory address
exmem_rt_data_d / exmem_rt_data_q  in / out  DATA_W  store data
exmem_zero_d / exmem_zero_q  in / out  1  ALU zero flag
exmem_dest_addr_d / exmem_dest_addr_q  in / out  RADDR_W  write-back register address
exmem_ctrl_d / exmem_ctrl_q  in / out  6  {jump[5], branch[4], mem_read[3], mem_to_reg[2], mem_write[1], reg_write[0]}

Behaviour:
- All `_q` outputs are purely registered. There is no combinational path from `_d` to `_q`; latency is exactly 1 clk per bank.
- reset low: every `_q` clears to 0 immediately, independent of clk. An all-zero instruction is a NOP and all-zero controls are a bubble.
- Reset release: the first capture happens at the next rising clk edge with reset high.
- While reset is low, clk edges have no effect. Asserting reset mid-stream discards all in-flight contents.
- IF/ID: ifid_en=1 captures pc and instr on the rising edge; ifid_en=0 holds both values unchanged.
- ID/EX captures every rising edge (no enable).
  - idex_stall=1: idex_ctrl_q is loaded with 0 (bubble: reg_write, mem_write, mem_read, branch and jump all 0).
  - idex_stall=1: all ID/EX data and address fields are still captured from `_d`.
  - idex_stall=0: ctrl is captured normally.
- EX/MEM captures all fields every rising edge, unconditionally.
- The banks are independent. Simultaneous ifid_en=0 and idex_stall=1 (the normal stall cycle) holds IF/ID while ID/EX takes a bubble.
- No wrap or arithmetic is performed; widths pass through unchanged.

Test Plan:
- Hold reset low for 2 edges with nonzero `_d` values -> every `_q` = 0. Release and drive ifid_instr_d=0x8C220004, ifid_pc_d=5 -> after 1 edge ifid_instr_q=0x8C220004, ifid_pc_q=5.
- ifid_en=0 with ifid_instr_d changed to 0x00430820 -> ifid_instr_q stays 0x8C220004. Set ifid_en=1 -> it updates on the next edge.
- idex_ctrl_d=10'b1000000011, idex_rt_addr_d=3, idex_stall=0 -> idex_ctrl_q=0x203, rt_addr_q=3. Repeat with idex_stall=1 -> idex_ctrl_q=0 and idex_rt_addr_q=3.
- exmem_alu_res_d=0x10, exmem_zero_d=1, exmem_ctrl_d=6'b001001, exmem_dest_addr_d=9 -> all appear on the `_q` outputs after 1 edge. They change again on the following edge.
- Pulse reset low between clk edges while all banks are loaded -> outputs clear immediately, before the next edge. They reload on the first edge after release.

Source files
------------

// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs: IF/ID, ID/EX and EX/MEM forward register banks of the 5-stage core.
// Every output is a flop; an asynchronous active-low reset clears all banks to NOP/bubble.
module pipeline_stage_regs #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ifid_en,
    input  logic [DATA_W-1:0]  i_ifid_pc_d,
    input  logic [31:0]        i_ifid_instr_d,
    output logic [DATA_W-1:0]  o_ifid_pc_q,
    output logic [31:0]        o_ifid_instr_q,
    input  logic               i_idex_stall,
    input  logic [DATA_W-1:0]  i_idex_pc_d,
    input  logic [DATA_W-1:0]  i_idex_rs_data_d,
    input  logic [DATA_W-1:0]  i_idex_rt_data_d,
    input  logic [DATA_W-1:0]  i_idex_imm_d,
    input  logic [RADDR_W-1:0] i_idex_rs_addr_d,
    input  logic [RADDR_W-1:0] i_idex_rt_addr_d,
    input  logic [RADDR_W-1:0] i_idex_rd_addr_d,
    input  logic [31:0]        i_idex_instr_d,
    input  logic [9:0]         i_idex_ctrl_d,
    output logic [DATA_W-1:0]  o_idex_pc_q,
    output logic [DATA_W-1:0]  o_idex_rs_data_q,
    output logic [DATA_W-1:0]  o_idex_rt_data_q,
    output logic [DATA_W-1:0]  o_idex_imm_q,
    output logic [RADDR_W-1:0] o_idex_rs_addr_q,
    output logic [RADDR_W-1:0] o_idex_rt_addr_q,
    output logic [RADDR_W-1:0] o_idex_rd_addr_q,
    output logic [31:0]        o_idex_instr_q,
    output logic [9:0]         o_idex_ctrl_q,
    input  logic [DATA_W-1:0]  i_exmem_branch_addr_d,
    input  logic [DATA_W-1:0]  i_exmem_alu_res_d,
    input  logic [DATA_W-1:0]  i_exmem_rt_data_d,
    input  logic               i_exmem_zero_d,
    input  logic [RADDR_W-1:0] i_exmem_dest_addr_d,
    input  logic [5:0]         i_exmem_ctrl_d,
    output logic [DATA_W-1:0]  o_exmem_branch_addr_q,
    output logic [DATA_W-1:0]  o_exmem_alu_res_q,
    output logic [DATA_W-1:0]  o_exmem_rt_data_q,
    output logic               o_exmem_zero_q,
    output logic [RADDR_W-1:0] o_exmem_dest_addr_q,
    output logic [5:0]         o_exmem_ctrl_q
);
    logic [DATA_W-1:0]  r_ifid_pc;
    logic [31:0]        r_ifid_instr;
    logic [DATA_W-1:0]  r_idex_pc;
    logic [DATA_W-1:0]  r_idex_rs_data;
    logic [DATA_W-1:0]  r_idex_rt_data;
    logic [DATA_W-1:0]  r_idex_imm;
    logic [RADDR_W-1:0] r_idex_rs_addr;
    logic [RADDR_W-1:0] r_idex_rt_addr;
    logic [RADDR_W-1:0] r_idex_rd_addr;
    logic [31:0]        r_idex_instr;
    logic [9:0]         r_idex_ctrl;
    logic [DATA_W-1:0]  r_exmem_branch_addr;
    logic [DATA_W-1:0]  r_exmem_alu_res;
    logic [DATA_W-1:0]  r_exmem_rt_data;
    logic               r_exmem_zero;
    logic [RADDR_W-1:0] r_exmem_dest_addr;
    logic [5:0]         r_exmem_ctrl;
    logic [9:0]         w_idex_ctrl_next;

    // A stall only kills the controls; data still flows so forwarding sees consistent operands.
    assign w_idex_ctrl_next = i_idex_stall ? 10'd0 : i_idex_ctrl_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
        end else if (i_ifid_en) begin
            r_ifid_pc    <= i_ifid_pc_d;
            r_ifid_instr <= i_ifid_instr_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idex_pc      <= '0;
            r_idex_rs_data <= '0;
            r_idex_rt_data <= '0;
            r_idex_imm     <= '0;
            r_idex_rs_addr <= '0;
            r_idex_rt_addr <= '0;
            r_idex_rd_addr <= '0;
            r_idex_instr   <= '0;
            r_idex_ctrl    <= '0;
        end else begin
            r_idex_pc      <= i_idex_pc_d;
            r_idex_rs_data <= i_idex_rs_data_d;
            r_idex_rt_data <= i_idex_rt_data_d;
            r_idex_imm     <= i_idex_imm_d;
            r_idex_rs_addr <= i_idex_rs_addr_d;
            r_idex_rt_addr <= i_idex_rt_addr_d;
            r_idex_rd_addr <= i_idex_rd_addr_d;
            r_idex_instr   <= i_idex_instr_d;
            r_idex_ctrl    <= w_idex_ctrl_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exmem_branch_addr <= '0;
            r_exmem_alu_res     <= '0;
            r_exmem_rt_data     <= '0;
            r_exmem_zero        <= 1'b0;
            r_exmem_dest_addr   <= '0;
            r_exmem_ctrl        <= '0;
        end else begin
            r_exmem_branch_addr <= i_exmem_branch_addr_d;
            r_exmem_alu_res     <= i_exmem_alu_res_d;
            r_exmem_rt_data     <= i_exmem_rt_data_d;
            r_exmem_zero        <= i_exmem_zero_d;
            r_exmem_dest_addr   <= i_exmem_dest_addr_d;
            r_exmem_ctrl        <= i_exmem_ctrl_d;
        end
    end

    assign o_ifid_pc_q           = r_ifid_pc;
    assign o_ifid_instr_q        = r_ifid_instr;
    assign o_idex_pc_q           = r_idex_pc;
    assign o_idex_rs_data_q      = r_idex_rs_data;
    assign o_idex_rt_data_q      = r_idex_rt_data;
    assign o_idex_imm_q          = r_idex_imm;
    assign o_idex_rs_addr_q      = r_idex_rs_addr;
    assign o_idex_rt_addr_q      = r_idex_rt_addr;
    assign o_idex_rd_addr_q      = r_idex_rd_addr;
    assign o_idex_instr_q        = r_idex_instr;
    assign o_idex_ctrl_q         = r_idex_ctrl;
    assign o_exmem_branch_addr_q = r_exmem_branch_addr;
    assign o_exmem_alu_res_q     = r_exmem_alu_res;
    assign o_exmem_rt_data_q     = r_exmem_rt_data;
    assign o_exmem_zero_q        = r_exmem_zero;
    assign o_exmem_dest_addr_q   = r_exmem_dest_addr;
    assign o_exmem_ctrl_q        = r_exmem_ctrl;
endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb_pipeline_stage_regs: directed and randomized checks of the three pipeline banks
// against a bank-level model (each bank = last accepted input bundle, zero after reset).
module tb_pipeline_stage_regs;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifid_en;
    logic [DW-1:0] ifid_pc_d, ifid_pc_q;
    logic [31:0]   ifid_instr_d, ifid_instr_q;
    logic          idex_stall;
    logic [DW-1:0] idex_pc_d, idex_rs_data_d, idex_rt_data_d, idex_imm_d;
    logic [DW-1:0] idex_pc_q, idex_rs_data_q, idex_rt_data_q, idex_imm_q;
    logic [AW-1:0] idex_rs_addr_d, idex_rt_addr_d, idex_rd_addr_d;
    logic [AW-1:0] idex_rs_addr_q, idex_rt_addr_q, idex_rd_addr_q;
    logic [31:0]   idex_instr_d, idex_instr_q;
    logic [9:0]    idex_ctrl_d, idex_ctrl_q;
    logic [DW-1:0] exmem_branch_addr_d, exmem_alu_res_d, exmem_rt_data_d;
    logic [DW-1:0] exmem_branch_addr_q, exmem_alu_res_q, exmem_rt_data_q;
    logic          exmem_zero_d, exmem_zero_q;
    logic [AW-1:0] exmem_dest_addr_d, exmem_dest_addr_q;
    logic [5:0]    exmem_ctrl_d, exmem_ctrl_q;

    int checks = 0;
    int failures = 0;

    logic [255:0] m_ifid, m_idex, m_exmem;

    pipeline_stage_regs #(.DATA_W(DW), .RADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ifid_en(ifid_en),
        .i_ifid_pc_d(ifid_pc_d), .i_ifid_instr_d(ifid_instr_d),
        .o_ifid_pc_q(ifid_pc_q), .o_ifid_instr_q(ifid_instr_q),
        .i_idex_stall(idex_stall),
        .i_idex_pc_d(idex_pc_d), .i_idex_rs_data_d(idex_rs_data_d),
        .i_idex_rt_data_d(idex_rt_data_d), .i_idex_imm_d(idex_imm_d),
        .i_idex_rs_addr_d(idex_rs_addr_d), .i_idex_rt_addr_d(idex_rt_addr_d),
        .i_idex_rd_addr_d(idex_rd_addr_d), .i_idex_instr_d(idex_instr_d),
        .i_idex_ctrl_d(idex_ctrl_d),
        .o_idex_pc_q(idex_pc_q), .o_idex_rs_data_q(idex_rs_data_q),
        .o_idex_rt_data_q(idex_rt_data_q), .o_idex_imm_q(idex_imm_q),
        .o_idex_rs_addr_q(idex_rs_addr_q), .o_idex_rt_addr_q(idex_rt_addr_q),
        .o_idex_rd_addr_q(idex_rd_addr_q), .o_idex_instr_q(idex_instr_q),
        .o_idex_ctrl_q(idex_ctrl_q),
        .i_exmem_branch_addr_d(exmem_branch_addr_d), .i_exmem_alu_res_d(exmem_alu_res_d),
        .i_exmem_rt_data_d(exmem_rt_data_d), .i_exmem_zero_d(exmem_zero_d),
        .i_exmem_dest_addr_d(exmem_dest_addr_d), .i_exmem_ctrl_d(exmem_ctrl_d),
        .o_exmem_branch_addr_q(exmem_branch_addr_q), .o_exmem_alu_res_q(exmem_alu_res_q),
        .o_exmem_rt_data_q(exmem_rt_data_q), .o_exmem_zero_q(exmem_zero_q),
        .o_exmem_dest_addr_q(exmem_dest_addr_q), .o_exmem_ctrl_q(exmem_ctrl_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":ifid"}, 256'({ifid_pc_q, ifid_instr_q}), m_ifid);
        check({tag, ":idex"}, 256'({idex_pc_q, idex_rs_data_q, idex_rt_data_q, idex_imm_q,
              idex_rs_addr_q, idex_rt_addr_q, idex_rd_addr_q, idex_instr_q, idex_ctrl_q}), m_idex);
        check({tag, ":exmem"}, 256'({exmem_branch_addr_q, exmem_alu_res_q, exmem_rt_data_q,
              exmem_zero_q, exmem_dest_addr_q, exmem_ctrl_q}), m_exmem);
    endtask

    task automatic randomize_inputs();
        ifid_pc_d = $urandom; ifid_instr_d = $urandom;
        idex_pc_d = $urandom; idex_rs_data_d = $urandom; idex_rt_data_d = $urandom;
        idex_imm_d = $urandom; idex_instr_d = $urandom;
        idex_rs_addr_d = AW'($urandom_range(31)); idex_rt_addr_d = AW'($urandom_range(31));
        idex_rd_addr_d = AW'($urandom_range(31)); idex_ctrl_d = 10'($urandom_range(1023));
        exmem_branch_addr_d = $urandom; exmem_alu_res_d = $urandom; exmem_rt_data_d = $urandom;
        exmem_zero_d = 1'($urandom_range(1)); exmem_dest_addr_d = AW'($urandom_range(31));
        exmem_ctrl_d = 6'($urandom_range(63));
    endtask

    task automatic clear_model();
        m_ifid = '0; m_idex = '0; m_exmem = '0;
    endtask

    // Model: each bank shows what it accepted at the last edge out of reset.
    task automatic tick(input string tag);
        if (rst_n) begin
            if (ifid_en) m_ifid = 256'({ifid_pc_d, ifid_instr_d});
            m_idex = 256'({idex_pc_d, idex_rs_data_d, idex_rt_data_d, idex_imm_d, idex_rs_addr_d,
                     idex_rt_addr_d, idex_rd_addr_d, idex_instr_d, idex_stall ? 10'd0 : idex_ctrl_d});
            m_exmem = 256'({exmem_branch_addr_d, exmem_alu_res_d, exmem_rt_data_d, exmem_zero_d,
                      exmem_dest_addr_d, exmem_ctrl_d});
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; ifid_en = 1'b1; idex_stall = 1'b0;
        randomize_inputs();
        clear_model();
        #1 check_all("reset_async");
        tick("reset_edge1");
        tick("reset_edge2");

        rst_n = 1'b1;
        ifid_instr_d = 32'h8C220004; ifid_pc_d = 32'd5;
        tick("release_first");
        check("ifid_instr_lw", 256'(ifid_instr_q), 256'(32'h8C220004));
        check("ifid_pc_5", 256'(ifid_pc_q), 256'(32'd5));

        ifid_en = 1'b0; ifid_instr_d = 32'h00430820;
        tick("ifid_hold");
        check("ifid_hold_instr", 256'(ifid_instr_q), 256'(32'h8C220004));
        ifid_en = 1'b1;
        tick("ifid_resume");
        check("ifid_resume_instr", 256'(ifid_instr_q), 256'(32'h00430820));

        idex_ctrl_d = 10'b1000000011; idex_rt_addr_d = 5'd3; idex_stall = 1'b0;
        tick("idex_normal");
        check("idex_ctrl_203", 256'(idex_ctrl_q), 256'(10'h203));
        check("idex_rt_3", 256'(idex_rt_addr_q), 256'(5'd3));
        idex_stall = 1'b1;
        tick("idex_bubble");
        check("idex_ctrl_bubble", 256'(idex_ctrl_q), 256'(10'h0));
        check("idex_rt_3_stall", 256'(idex_rt_addr_q), 256'(5'd3));

        ifid_en = 1'b0; ifid_instr_d = 32'h12345678;
        tick("stall_cycle");
        check("stall_ifid_held", 256'(ifid_instr_q), 256'(32'h00430820));
        ifid_en = 1'b1; idex_stall = 1'b0;

        exmem_alu_res_d = 32'h10; exmem_zero_d = 1'b1; exmem_ctrl_d = 6'b001001;
        exmem_dest_addr_d = 5'd9;
        tick("exmem_load");
        check("exmem_alu_10", 256'(exmem_alu_res_q), 256'(32'h10));
        check("exmem_zero_1", 256'(exmem_zero_q), 256'(1'b1));
        check("exmem_ctrl_09", 256'(exmem_ctrl_q), 256'(6'b001001));
        check("exmem_dest_9", 256'(exmem_dest_addr_q), 256'(5'd9));
        exmem_alu_res_d = 32'h20; exmem_zero_d = 1'b0; exmem_ctrl_d = 6'b000000;
        exmem_dest_addr_d = 5'd17;
        tick("exmem_next");
        check("exmem_alu_20", 256'(exmem_alu_res_q), 256'(32'h20));

        randomize_inputs();
        #2 check_all("no_comb_path");

        tick("preload");
        #2 rst_n = 1'b0;
        clear_model();
        #1 check_all("midcycle_reset");
        #1 rst_n = 1'b1;
        randomize_inputs();
        tick("reload_after_reset");

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            ifid_en = 1'($urandom_range(1));
            idex_stall = ($urandom_range(3) == 0);
            if ($urandom_range(19) == 0) begin
                #2 rst_n = 1'b0;
                clear_model();
                #1 check_all("rand_reset");
                if ($urandom_range(1) == 1) tick("rand_reset_held");
                #1 rst_n = 1'b1;
            end
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
